// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Includes the FSM state encoding, the latency counter width and a lane-mask expander.
package dmem_pkg;

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef struct packed {
      logic [31:0] addr;
      logic        ren;
      logic        wen;
      logic [3:0]  mask;
      logic [31:0] wdata;
   } req_t;

   // Expand a 4-bit byte-lane enable into a 32-bit bit mask.
   function automatic logic [31:0] lane_bits(input logic [3:0] mask);
      lane_bits = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with a synchronous byte-enable write port
// and a combinational read port. Contents are never reset.
module dmem_array #(
   parameter int unsigned DEPTH_WORDS = 1024,
   localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
   input  logic          i_clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [3:0]    i_wbe,
   input  logic [31:0]   i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [31:0]   o_rdata
);

   logic [31:0] mem_q [DEPTH_WORDS];

   // Byte-lane write.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         for (int b = 0; b < 4; b++) begin
            if (i_wbe[b]) begin
               mem_q[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
         end
      end
   end

   assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed response latency,
// request validation and byte-lane masking around a dmem_array.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic [31:0] i_req_addr,
   input  logic        i_req_ren,
   input  logic        i_req_wen,
   input  logic [3:0]  i_req_mask,
   input  logic [31:0] i_req_wdata,
   output logic        o_rsp_valid,
   output logic [31:0] o_rsp_rdata,
   output logic        o_rsp_err
);

   localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   req_t             req_q, req_d;
   logic             ready_q, ready_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [31:0]      rsp_rdata_q, rsp_rdata_d;
   logic             rsp_err_q, rsp_err_d;

   req_t             cur_s;
   logic [31:0]      offset_s;
   logic [AW-1:0]    widx_s;
   logic             err_s;
   logic             fire_s;
   logic             we_s;
   logic [31:0]      rd_word_s;

   // The request under evaluation: live inputs while idle, the captured copy afterwards.
   always_comb begin
      if (state_q == IDLE) begin
         cur_s = '{addr: i_req_addr, ren: i_req_ren, wen: i_req_wen,
                   mask: i_req_mask, wdata: i_req_wdata};
      end else begin
         cur_s = req_q;
      end
      offset_s = cur_s.addr - BASE_ADDR;
      widx_s   = offset_s[AW+1:2];
      err_s    = (cur_s.ren == cur_s.wen) || (cur_s.addr[1:0] != 2'b00) ||
                 (cur_s.mask == 4'b0000) || ((offset_s >> 2) >= 32'(DEPTH_WORDS));
   end

   // A rejected request never reaches storage; reset in RESP drops the write too.
   assign we_s = (state_q == RESP) && req_q.wen && !rsp_err_q && !i_rst;

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_array (
      .i_clk   (i_clk),
      .i_we    (we_s),
      .i_waddr (widx_s),
      .i_wbe   (req_q.mask),
      .i_wdata (req_q.wdata),
      .i_raddr (widx_s),
      .o_rdata (rd_word_s)
   );

   // Next-state, counter and response computation.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      req_d       = req_q;
      fire_s      = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = 32'h0000_0000;
      rsp_err_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_req_valid) begin
               req_d = cur_s;
               if (LATENCY == 1) begin
                  state_d = RESP;
                  fire_s  = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_LOAD;
               end
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = RESP;
               fire_s  = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // Response is formed the cycle before RESP so the outputs can be registered.
      if (fire_s) begin
         rsp_valid_d = 1'b1;
         rsp_err_d   = err_s;
         if (err_s) begin
            rsp_rdata_d = 32'h0000_0000;
         end else begin
            rsp_rdata_d = rd_word_s & lane_bits(cur_s.mask);
         end
      end else begin
         rsp_valid_d = 1'b0;
      end

      ready_d = (state_d == IDLE);
   end

   // FSM and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         req_q       <= '0;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0000_0000;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_q       <= req_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign o_req_ready = ready_q;
   assign o_rsp_valid = rsp_valid_q;
   assign o_rsp_rdata = rsp_rdata_q;
   assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: three responders (LATENCY 1, 2, 15) driven by directed
// and randomized requests, checked against a byte-level memory model.
module tb_dmem_responder;

   localparam int LAT_OF [3] = '{1, 2, 15};

   logic        clk;
   logic        rst        [3];
   logic        req_valid  [3];
   logic        rdy        [3];
   logic [31:0] req_addr   [3];
   logic        req_ren    [3];
   logic        req_wen    [3];
   logic [3:0]  req_mask   [3];
   logic [31:0] req_wdata  [3];
   logic        rsp_valid  [3];
   logic [31:0] rsp_rdata  [3];
   logic        rsp_err    [3];

   logic [31:0] mdl_mem [3][1024];
   logic [3:0]  mdl_kn  [3][1024];

   int n_total = 0;
   int n_pass  = 0;

   dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1), .BASE_ADDR(32'h0000_0000)) u_lat1 (
      .i_clk(clk), .i_rst(rst[0]), .i_req_valid(req_valid[0]), .o_req_ready(rdy[0]),
      .i_req_addr(req_addr[0]), .i_req_ren(req_ren[0]), .i_req_wen(req_wen[0]),
      .i_req_mask(req_mask[0]), .i_req_wdata(req_wdata[0]), .o_rsp_valid(rsp_valid[0]),
      .o_rsp_rdata(rsp_rdata[0]), .o_rsp_err(rsp_err[0]));

   dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(32'h0000_0000)) u_lat2 (
      .i_clk(clk), .i_rst(rst[1]), .i_req_valid(req_valid[1]), .o_req_ready(rdy[1]),
      .i_req_addr(req_addr[1]), .i_req_ren(req_ren[1]), .i_req_wen(req_wen[1]),
      .i_req_mask(req_mask[1]), .i_req_wdata(req_wdata[1]), .o_rsp_valid(rsp_valid[1]),
      .o_rsp_rdata(rsp_rdata[1]), .o_rsp_err(rsp_err[1]));

   dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(15), .BASE_ADDR(32'h0000_0000)) u_lat15 (
      .i_clk(clk), .i_rst(rst[2]), .i_req_valid(req_valid[2]), .o_req_ready(rdy[2]),
      .i_req_addr(req_addr[2]), .i_req_ren(req_ren[2]), .i_req_wen(req_wen[2]),
      .i_req_mask(req_mask[2]), .i_req_wdata(req_wdata[2]), .o_rsp_valid(rsp_valid[2]),
      .o_rsp_rdata(rsp_rdata[2]), .o_rsp_err(rsp_err[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: legality rules plus a byte-addressed store; unknown lanes are excluded via cmp.
   task automatic model_access(input int i, input logic [31:0] a, input logic r, input logic w,
                               input logic [3:0] m, input logic [31:0] wd,
                               output logic e, output logic [31:0] rd, output logic [31:0] cmp);
      logic [31:0] off;
      int idx;
      off = a - 32'h0000_0000;
      e   = (r == w) || (a[1:0] != 2'b00) || (m == 4'b0000) || ((off >> 2) >= 32'd1024);
      rd  = 32'h0;
      cmp = 32'hFFFF_FFFF;
      if (!e) begin
         idx = int'(off >> 2);
         for (int b = 0; b < 4; b++) begin
            if (m[b] && w) begin
               mdl_mem[i][idx][8*b +: 8] = wd[8*b +: 8];
               mdl_kn[i][idx][b] = 1'b1;
            end else if (m[b]) begin
               rd[8*b +: 8] = mdl_mem[i][idx][8*b +: 8];
               if (!mdl_kn[i][idx][b]) cmp[8*b +: 8] = 8'h00;
            end
         end
      end
   endtask

   // One request on instance i; returns the observed delay, response and a side-condition flag.
   task automatic do_req(input int i, input logic [31:0] a, input logic r, input logic w,
                         input logic [3:0] m, input logic [31:0] wd,
                         output int d, output logic e, output logic [31:0] rd, output bit ok);
      ok = 1'b1;
      @(negedge clk);
      if (rdy[i] !== 1'b1 || rsp_valid[i] !== 1'b0) ok = 1'b0;
      req_valid[i] = 1'b1; req_addr[i] = a; req_ren[i] = r; req_wen[i] = w;
      req_mask[i] = m; req_wdata[i] = wd;
      @(posedge clk);
      @(negedge clk);
      req_valid[i] = 1'b0; req_addr[i] = $urandom; req_ren[i] = 1'b1; req_wen[i] = 1'b1;
      req_mask[i] = 4'hF; req_wdata[i] = $urandom;
      d = 1;
      while (rsp_valid[i] !== 1'b1 && d < 40) begin
         if (rdy[i] !== 1'b0 || rsp_rdata[i] !== 32'h0 || rsp_err[i] !== 1'b0) ok = 1'b0;
         @(negedge clk);
         d++;
      end
      e  = rsp_err[i];
      rd = rsp_rdata[i];
      if (rdy[i] !== 1'b0) ok = 1'b0;
   endtask

   task automatic xact(input int i, input logic [31:0] a, input logic r, input logic w,
                       input logic [3:0] m, input logic [31:0] wd,
                       output int d, output logic e, output logic [31:0] rd, output bit ok);
      logic        me;
      logic [31:0] mr, mc;
      model_access(i, a, r, w, m, wd, me, mr, mc);
      do_req(i, a, r, w, m, wd, d, e, rd, ok);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) rst[i] = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         n_total++; if (rdy[i] !== 1'b1) $display("FAIL reset_ready[%0d]: got %b want 1", i, rdy[i]); else n_pass++;
         n_total++; if (rsp_valid[i] !== 1'b0) $display("FAIL reset_valid[%0d]: got %b want 0", i, rsp_valid[i]); else n_pass++;
         n_total++; if (rsp_rdata[i] !== 32'h0) $display("FAIL reset_rdata[%0d]: got %h want 0", i, rsp_rdata[i]); else n_pass++;
         n_total++; if (rsp_err[i] !== 1'b0) $display("FAIL reset_err[%0d]: got %b want 0", i, rsp_err[i]); else n_pass++;
      end
      for (int i = 0; i < 3; i++) rst[i] = 1'b0;
   endtask

   task automatic test_write_read();
      int d; logic e; logic [31:0] r; bit ok;
      xact(1, 32'h10, 1'b0, 1'b1, 4'b1111, 32'hDEADBEEF, d, e, r, ok);
      n_total++; if (d != 2 || e !== 1'b0 || !ok) $display("FAIL wr_0x10: dly=%0d err=%b ok=%0b want 2 0 1", d, e, ok); else n_pass++;
      xact(1, 32'h10, 1'b1, 1'b0, 4'b1111, 32'h0, d, e, r, ok);
      n_total++; if (d != 2 || e !== 1'b0 || r !== 32'hDEADBEEF || !ok) $display("FAIL rd_0x10: dly=%0d err=%b rdata=%h ok=%0b want 2 0 deadbeef 1", d, e, r, ok); else n_pass++;
   endtask

   task automatic test_partial_write();
      int d; logic e; logic [31:0] r; bit ok;
      xact(1, 32'h20, 1'b0, 1'b1, 4'b1111, 32'h11223344, d, e, r, ok);
      n_total++; if (e !== 1'b0 || !ok) $display("FAIL preload_0x20: err=%b ok=%0b want 0 1", e, ok); else n_pass++;
      xact(1, 32'h20, 1'b0, 1'b1, 4'b1000, 32'hAA000000, d, e, r, ok);
      n_total++; if (e !== 1'b0 || !ok) $display("FAIL pwr_0x20: err=%b ok=%0b want 0 1", e, ok); else n_pass++;
      xact(1, 32'h20, 1'b1, 1'b0, 4'b1111, 32'h0, d, e, r, ok);
      n_total++; if (e !== 1'b0 || r !== 32'hAA223344) $display("FAIL prd_full: err=%b rdata=%h want 0 aa223344", e, r); else n_pass++;
      xact(1, 32'h20, 1'b1, 1'b0, 4'b0011, 32'h0, d, e, r, ok);
      n_total++; if (e !== 1'b0 || r !== 32'h00003344) $display("FAIL prd_low: err=%b rdata=%h want 0 00003344", e, r); else n_pass++;
   endtask

   task automatic test_errors();
      int d; logic e; logic [31:0] r; bit ok;
      xact(1, 32'h0, 1'b0, 1'b1, 4'b1111, 32'h12345678, d, e, r, ok);
      xact(1, 32'h0, 1'b1, 1'b1, 4'b1111, 32'hFFFFFFFF, d, e, r, ok);
      n_total++; if (d != 2 || e !== 1'b1 || r !== 32'h0) $display("FAIL err_renwen: dly=%0d err=%b rdata=%h want 2 1 0", d, e, r); else n_pass++;
      xact(1, 32'h0, 1'b1, 1'b0, 4'b1111, 32'h0, d, e, r, ok);
      n_total++; if (e !== 1'b0 || r !== 32'h12345678) $display("FAIL err_unchanged: err=%b rdata=%h want 0 12345678", e, r); else n_pass++;
      xact(1, 32'h3, 1'b1, 1'b0, 4'b1111, 32'h0, d, e, r, ok);
      n_total++; if (e !== 1'b1 || r !== 32'h0) $display("FAIL err_misalign: err=%b rdata=%h want 1 0", e, r); else n_pass++;
      xact(1, 32'h1000, 1'b1, 1'b0, 4'b1111, 32'h0, d, e, r, ok);
      n_total++; if (e !== 1'b1 || r !== 32'h0) $display("FAIL err_range: err=%b rdata=%h want 1 0", e, r); else n_pass++;
      xact(1, 32'h4, 1'b1, 1'b0, 4'b0000, 32'h0, d, e, r, ok);
      n_total++; if (e !== 1'b1) $display("FAIL err_mask0: err=%b want 1", e); else n_pass++;
      xact(1, 32'hFFC, 1'b0, 1'b1, 4'b1111, 32'hCAFEF00D, d, e, r, ok);
      xact(1, 32'hFFC, 1'b1, 1'b0, 4'b1111, 32'h0, d, e, r, ok);
      n_total++; if (e !== 1'b0 || r !== 32'hCAFEF00D) $display("FAIL last_word: err=%b rdata=%h want 0 cafef00d", e, r); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int d; logic e; logic [31:0] r; bit ok;
      logic [31:0] vals [4];
      int acc;
      for (int k = 0; k < 4; k++) begin
         vals[k] = $urandom;
         xact(0, 32'h100 + 32'(4 * k), 1'b0, 1'b1, 4'b1111, vals[k], d, e, r, ok);
      end
      acc = 0;
      @(negedge clk);
      for (int cyc = 0; cyc < 8; cyc++) begin
         n_total++; if (rdy[0] !== ((cyc % 2) == 0)) $display("FAIL b2b_ready[%0d]: got %b want %0b", cyc, rdy[0], (cyc % 2) == 0); else n_pass++;
         n_total++; if (rsp_valid[0] !== ((cyc % 2) == 1)) $display("FAIL b2b_valid[%0d]: got %b want %0b", cyc, rsp_valid[0], (cyc % 2) == 1); else n_pass++;
         if ((cyc % 2) == 1) begin
            n_total++; if (rsp_rdata[0] !== vals[cyc / 2]) $display("FAIL b2b_rdata[%0d]: got %h want %h", cyc, rsp_rdata[0], vals[cyc / 2]); else n_pass++;
         end
         if (rdy[0] === 1'b1 && acc < 4) begin
            req_valid[0] = 1'b1; req_addr[0] = 32'h100 + 32'(4 * acc);
            req_ren[0] = 1'b1; req_wen[0] = 1'b0; req_mask[0] = 4'b1111;
            acc++;
         end else if (acc >= 4 && (cyc % 2) == 1) begin
            req_valid[0] = 1'b0;
         end
         @(negedge clk);
      end
      req_valid[0] = 1'b0;
      n_total++; if (acc != 4) $display("FAIL b2b_accepts: got %0d want 4", acc); else n_pass++;
   endtask

   task automatic test_reset_mid_write();
      int d; logic e; logic [31:0] r; bit ok;
      logic [31:0] prior;
      int seen;
      for (int i = 1; i < 3; i++) begin
         prior = $urandom;
         xact(i, 32'h40, 1'b0, 1'b1, 4'b1111, prior, d, e, r, ok);
         @(negedge clk);
         req_valid[i] = 1'b1; req_addr[i] = 32'h40; req_ren[i] = 1'b0; req_wen[i] = 1'b1;
         req_mask[i] = 4'b1111; req_wdata[i] = 32'h55;
         @(posedge clk);
         @(negedge clk);
         req_valid[i] = 1'b0;
         rst[i] = 1'b1;
         @(negedge clk);
         rst[i] = 1'b0;
         seen = 0;
         for (int k = 0; k < 20; k++) begin
            if (rsp_valid[i] === 1'b1) seen++;
            @(negedge clk);
         end
         n_total++; if (seen != 0) $display("FAIL rst_norsp[%0d]: got %0d pulses want 0", i, seen); else n_pass++;
         xact(i, 32'h40, 1'b1, 1'b0, 4'b1111, 32'h0, d, e, r, ok);
         n_total++; if (e !== 1'b0 || r !== prior) $display("FAIL rst_prior[%0d]: err=%b rdata=%h want 0 %h", i, e, r, prior); else n_pass++;
      end
   endtask

   task automatic test_latency_sweep();
      int d; logic e; logic [31:0] r; bit ok;
      logic [31:0] v;
      for (int i = 0; i < 3; i++) begin
         v = $urandom;
         xact(i, 32'h200, 1'b0, 1'b1, 4'b1111, v, d, e, r, ok);
         n_total++; if (d != LAT_OF[i] || !ok) $display("FAIL lat_wr[%0d]: dly=%0d ok=%0b want %0d 1", i, d, ok, LAT_OF[i]); else n_pass++;
         xact(i, 32'h200, 1'b1, 1'b0, 4'b1111, 32'h0, d, e, r, ok);
         n_total++; if (d != LAT_OF[i] || !ok || r !== v) $display("FAIL lat_rd[%0d]: dly=%0d ok=%0b rdata=%h want %0d 1 %h", i, d, ok, r, LAT_OF[i], v); else n_pass++;
      end
   endtask

   task automatic test_random();
      int d; logic e; logic [31:0] r; bit ok;
      logic me; logic [31:0] mr, mc;
      logic [31:0] a, wd;
      logic rr, ww;
      logic [3:0] m;
      int i, sel, rw;
      for (int k = 0; k < 60; k++) begin
         i   = $urandom_range(0, 2);
         sel = $urandom_range(0, 9);
         if (sel < 7) a = 32'($urandom_range(0, 63)) << 2;
         else if (sel == 7) a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
         else if (sel == 8) a = 32'h0000_1000 + (32'($urandom_range(0, 255)) << 2);
         else a = 32'hFFFF_FFFC;
         rw = $urandom_range(0, 7);
         rr = (rw == 1) || (rw >= 2 && rw <= 4);
         ww = (rw == 1) || (rw >= 5);
         m  = 4'($urandom_range(0, 15));
         wd = $urandom;
         model_access(i, a, rr, ww, m, wd, me, mr, mc);
         do_req(i, a, rr, ww, m, wd, d, e, r, ok);
         n_total++;
         if (d != LAT_OF[i] || !ok || e !== me || (r & mc) !== (mr & mc))
            $display("FAIL rand[%0d] inst%0d a=%h r=%b w=%b m=%b: dly=%0d ok=%0b err=%b rdata=%h want dly=%0d err=%b rdata=%h cmp=%h",
                     k, i, a, rr, ww, m, d, ok, e, r, LAT_OF[i], me, mr, mc);
         else n_pass++;
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         rst[i] = 1'b1; req_valid[i] = 1'b0; req_addr[i] = 32'h0; req_ren[i] = 1'b0;
         req_wen[i] = 1'b0; req_mask[i] = 4'h0; req_wdata[i] = 32'h0;
         for (int w = 0; w < 1024; w++) begin
            mdl_mem[i][w] = 32'h0;
            mdl_kn[i][w]  = 4'h0;
         end
      end
      test_reset();
      test_write_read();
      test_partial_write();
      test_errors();
      test_back_to_back();
      test_reset_mid_write();
      test_latency_sweep();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
